mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Synchronous front-end controller that sits directly upstream of the 64x64 asynchronous memory.
- Accepts word read/write requests from a client over a valid/ready handshake.
- Sequences the memory's MemRead/MemWrite/Addr strobes with setup, pulse and hold timing, and owns the tri-state drive of the shared DataBus.
- Returns read data to the client on a one-cycle response strobe; reads support short bursts with address wrap-around.

Parameters:
- ADDR_W, 6: memory address width (64 words).
- DATA_W, 64: word width.
- READ_WAIT, 2: cycles MemRead is held before DataBus is sampled (>=1).
- WR_PULSE, 1: cycles MemWrite is held high (>=1).
- LEN_W, 3: burst length field width (up to 8 beats).

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  client request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  start address.
- req_len  in  LEN_W  read beats minus 1; ignored for writes.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  one-cycle strobe per read beat.
- resp_rdata  out  DATA_W  read data, valid with resp_valid.
- busy  out  1  high whenever state != IDLE.
- MemWrite  out  1  memory write strobe.
- MemRead  out  1  memory read enable.
- Addr  out  ADDR_W  memory address.
- DataBus  inout  DATA_W  shared bidirectional memory data bus.

Behaviour:
- Reset values: req_ready=0 during reset and 1 the cycle after. resp_valid=0, resp_rdata=0, busy=0, MemWrite=0, MemRead=0, Addr=0. DataBus released (high-Z). State=IDLE.
- Handshake: a request is accepted on a rising edge with req_valid && req_ready.
  - req_ready=1 only in IDLE and not in reset.
  - req_addr, req_len, req_write and req_wdata are captured on acceptance. Later changes to these inputs are ignored.
- States: IDLE, W_SETUP, W_PULSE, W_HOLD, R_WAIT, R_DONE.
- Write path:
  - Accept -> W_SETUP (1 cycle): Addr=addr, DataBus driven with wdata, MemWrite=0.
  - W_PULSE (WR_PULSE cycles): MemWrite=1, Addr and data held.
  - W_HOLD (1 cycle): MemWrite=0, data still driven.
  - Then IDLE, bus released.
  - Total write occupancy: WR_PULSE+2 cycles after acceptance.
- Read path:
  - Accept -> R_WAIT: MemRead=1, Addr=addr, DataBus not driven.
  - After READ_WAIT cycles in R_WAIT, sample DataBus into resp_rdata and pulse resp_valid for exactly 1 cycle.
  - Beats remaining: Addr increments modulo 2^ADDR_W (63 -> 0 wrap) and R_WAIT repeats.
  - Last beat: go to R_DONE (1 cycle, MemRead=0), then IDLE.
  - First resp_valid occurs READ_WAIT cycles after the accept edge. Beat spacing is READ_WAIT cycles.
- Invariants:
  - MemRead and MemWrite are never high in the same cycle.
  - The controller drives DataBus only in W_SETUP, W_PULSE and W_HOLD.
  - MemRead is 0 in every write state.
- Back-to-back operation: a new request cannot be accepted until the cycle after the return to IDLE. There is no pipelining across requests.
- Reset mid-operation: the next edge with rst=1 forces IDLE and deasserts MemWrite/MemRead. DataBus is released immediately. A partial burst is abandoned and no further resp_valid is issued.
- Counters: wait/pulse counters are sized clog2 of their parameter + 1. The beat counter is LEN_W bits.

Decomposition:
- Package mem_ctrl_pkg holds:
  - the state enum;
  - ADDR_W/DATA_W defaults;
  - the command type (write bit, addr, len, wdata).
- Sub-module mem_bus_drv: tri-state DataBus driver plus sample register (drive enable, out data, captured in data). Everything else stays in mem_ctrl.

Test Plan:
- Reset: hold rst 3 cycles with req_valid=1 -> no acceptance. Memory strobes stay 0, DataBus stays Z. req_ready=1 the first cycle after rst falls.
- Single write then read:
  - Write addr 6'h05, data 64'hDEADBEEF_CAFEF00D -> MemWrite high exactly WR_PULSE cycles, with Addr=05 and data stable one cycle before and after the pulse.
  - Read 6'h05, len 0 -> one resp_valid with that data, 2 cycles after accept.
- Burst wrap: preload 6'h3E, 6'h3F, 6'h00, 6'h01 with 1..4, then read addr 6'h3E, len 3 -> four resp_valid pulses returning 1, 2, 3, 4. Addr sequence is 3E, 3F, 00, 01.
- Handshake:
  - req_valid held high across a read -> second request accepted only after IDLE.
  - Request inputs changed mid-op -> no effect on the current operation.
- Reset mid-burst: assert rst during beat 2 of a len=7 read -> no further resp_valid, MemRead=0 next edge, then a clean single read succeeds.
- Bus contention check: assertion throughout all tests that the controller never drives DataBus while MemRead=1, and MemRead and MemWrite are never high together.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the asynchronous memory front-end.
package mem_ctrl_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_LEN_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD,
        R_WAIT,
        R_DONE
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_LEN_W-1:0]  len;
        logic [DEF_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/mem_bus_drv.sv
// Tri-state DataBus driver and read-data sample register.
module mem_bus_drv #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              drop,
    input  logic              sample,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    inout  wire  [DATA_W-1:0] DataBus
);

    logic              oe;
    logic [DATA_W-1:0] dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            oe    <= 1'b0;
            dout  <= '0;
            rdata <= '0;
        end else begin
            if (load) begin
                oe   <= 1'b1;
                dout <= wdata;
            end else if (drop) begin
                oe <= 1'b0;
            end
            if (sample) begin
                rdata <= DataBus;
            end
        end
    end

    // Reset releases the bus without waiting for the clock edge.
    assign DataBus = (oe && !rst) ? dout : {DATA_W{1'bz}};

endmodule

// File: rtl/mem_ctrl.sv
// Synchronous controller sequencing strobes for a 64x64 asynchronous memory.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int READ_WAIT = 2,
    parameter int WR_PULSE  = 1,
    parameter int LEN_W     = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic              MemWrite,
    output logic              MemRead,
    output logic [ADDR_W-1:0] Addr,
    inout  wire  [DATA_W-1:0] DataBus
);

    localparam int RW_W = $clog2(READ_WAIT) + 1;
    localparam int WP_W = $clog2(WR_PULSE) + 1;
    localparam logic [RW_W-1:0] RW_LAST = RW_W'(READ_WAIT - 1);
    localparam logic [WP_W-1:0] WP_LAST = WP_W'(WR_PULSE - 1);

    state_t            state;
    cmd_t              req;
    logic [RW_W-1:0]   rcnt;
    logic [WP_W-1:0]   pcnt;
    logic [LEN_W-1:0]  beats;
    logic              accept;
    logic              drv_load;
    logic              drv_drop;
    logic              drv_sample;

    assign req = '{
        write: req_write,
        addr:  req_addr,
        len:   req_len,
        wdata: req_wdata
    };

    assign accept     = req_valid && req_ready;
    assign drv_load   = accept && req.write;
    assign drv_drop   = (state == W_HOLD);
    assign drv_sample = (state == R_WAIT) && (rcnt == RW_LAST);

    mem_bus_drv #(
        .DATA_W(DATA_W)
    ) u_drv (
        .clk    (clk),
        .rst    (rst),
        .load   (drv_load),
        .drop   (drv_drop),
        .sample (drv_sample),
        .wdata  (req.wdata),
        .rdata  (resp_rdata),
        .DataBus(DataBus)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            MemWrite   <= 1'b0;
            MemRead    <= 1'b0;
            Addr       <= '0;
            rcnt       <= '0;
            pcnt       <= '0;
            beats      <= '0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        Addr      <= req.addr;
                        if (req.write) begin
                            state <= W_SETUP;
                        end else begin
                            state   <= R_WAIT;
                            MemRead <= 1'b1;
                            rcnt    <= '0;
                            beats   <= req.len;
                        end
                    end
                end
                W_SETUP: begin
                    state    <= W_PULSE;
                    MemWrite <= 1'b1;
                    pcnt     <= '0;
                end
                W_PULSE: begin
                    if (pcnt == WP_LAST) begin
                        MemWrite <= 1'b0;
                        state    <= W_HOLD;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                W_HOLD: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                R_WAIT: begin
                    if (rcnt == RW_LAST) begin
                        resp_valid <= 1'b1;
                        rcnt       <= '0;
                        // MemRead stays high across beats; only Addr moves.
                        if (beats == '0) begin
                            MemRead <= 1'b0;
                            state   <= R_DONE;
                        end else begin
                            Addr  <= Addr + 1'b1;
                            beats <= beats - 1'b1;
                        end
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                R_DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl with an asynchronous memory model.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int RW = 2;
    localparam int WP = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [5:0]  req_addr = '0;
    logic [2:0]  req_len = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        busy;
    logic        memwrite;
    logic        memread;
    logic [5:0]  addr;
    wire  [63:0] databus;

    mem_ctrl #(
        .ADDR_W(6), .DATA_W(64), .READ_WAIT(RW),
        .WR_PULSE(WP), .LEN_W(3)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_len(req_len), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .busy(busy), .MemWrite(memwrite), .MemRead(memread),
        .Addr(addr), .DataBus(databus)
    );

    always #5 clk = ~clk;

    // Asynchronous memory model
    logic [63:0] mem [64];
    logic [63:0] shadow [64];
    assign databus = memread ? mem[addr] : {64{1'bz}};
    always @(negedge clk) if (memwrite) mem[addr] <= databus;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [5:0]  addr;
        logic [63:0] data;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    int nvec = 0;
    int nerr = 0;
    int nresp = 0;
    logic [5:0] addr_q = '0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    // Response scoreboard and bus-protocol monitor
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid === 1'b1) begin
            nresp++;
            nvec++;
            if (sbq.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_resp got=%h t=%0t", resp_rdata, $time);
            end else begin
                e = sbq.pop_front();
                if (resp_rdata !== e.data || cyc != e.cyc || addr_q !== e.addr) begin
                    nerr++;
                    $display("FAIL resp got=%h@%0d addr=%h want=%h@%0d addr=%h",
                             resp_rdata, cyc, addr_q, e.data, e.cyc, e.addr);
                end
            end
        end
        if (memread === 1'b1 && memwrite === 1'b1) begin
            nerr++;
            $display("FAIL strobe_overlap got=both_high want=exclusive t=%0t", $time);
        end
        if (memread === 1'b1 && dut.u_drv.oe === 1'b1) begin
            nerr++;
            $display("FAIL bus_contention got=driving want=released t=%0t", $time);
        end
        addr_q = addr;
    end

    task automatic do_req(input logic w, input logic [5:0] a,
                          input logic [2:0] l, input logic [63:0] d,
                          output int acc);
        @(negedge clk);
        req_write = w;
        req_addr  = a;
        req_len   = l;
        req_wdata = d;
        req_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 60; i++) begin
            if (req_ready === 1'b1) begin
                acc = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            nvec++;
            nerr++;
            $display("FAIL accept_timeout got=no_ready want=ready");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 6'($urandom);
        req_len   = 3'($urandom);
        req_wdata = {$urandom, $urandom};
        if (w) begin
            shadow[a] = d;
        end else begin
            for (int i = 0; i <= int'(l); i++) begin
                logic [5:0] ba;
                ba = a + 6'(i);
                sbq.push_back('{addr: ba, data: shadow[ba], cyc: acc + RW * (i + 1)});
            end
        end
    endtask

    task automatic wait_idle(output int c);
        c = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                c = cyc;
                return;
            end
        end
        nvec++;
        nerr++;
        $display("FAIL idle_timeout got=busy want=idle");
    endtask

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [2:0]  len;
        logic [63:0] wdata;
        int          occ;
    } vec_t;
    vec_t vecs[11];

    initial begin
        int acc, acc2, idle, base;
        logic [63:0] wd;
        for (int i = 0; i < 64; i++) begin
            mem[i] = '0;
            shadow[i] = '0;
        end

        vecs[0]  = '{1'b1, 6'h3E, 3'd0, 64'd1, WP + 2};
        vecs[1]  = '{1'b1, 6'h3F, 3'd0, 64'd2, WP + 2};
        vecs[2]  = '{1'b1, 6'h00, 3'd0, 64'd3, WP + 2};
        vecs[3]  = '{1'b1, 6'h01, 3'd0, 64'd4, WP + 2};
        vecs[4]  = '{1'b0, 6'h3E, 3'd3, 64'd0, 4 * RW + 1};
        vecs[5]  = '{1'b1, 6'h20, 3'd0, 64'hA5A5_5A5A_F0F0_0F0F, WP + 2};
        vecs[6]  = '{1'b0, 6'h20, 3'd0, 64'd0, RW + 1};
        vecs[7]  = '{1'b0, 6'h3F, 3'd2, 64'd0, 3 * RW + 1};
        vecs[8]  = '{1'b1, 6'h3F, 3'd0, 64'h0123_4567_89AB_CDEF, WP + 2};
        vecs[9]  = '{1'b0, 6'h3E, 3'd1, 64'd0, 2 * RW + 1};
        vecs[10] = '{1'b0, 6'h00, 3'd0, 64'd0, RW + 1};

        // Reset held with a pending request
        rst = 1'b1;
        req_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", 64'(req_ready), 64'd0);
            chk("rst_strobes", {62'd0, memread, memwrite}, 64'd0);
            chk("rst_oe", 64'(dut.u_drv.oe), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_addr", 64'(addr), 64'd0);
            chk("rst_resp", {resp_rdata[62:0], resp_valid}, 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(req_ready), 64'd1);
        chk("busy_after_rst", 64'(busy), 64'd0);
        req_valid = 1'b0;

        // Single write with setup/pulse/hold timing
        wd = 64'hDEADBEEF_CAFEF00D;
        do_req(1'b1, 6'h05, 3'd0, wd, acc);
        for (int k = 1; k <= WP + 3; k++) begin
            @(negedge clk);
            chk("wr_memwrite", 64'(memwrite),
                64'((k >= 2 && k <= WP + 1) ? 1 : 0));
            chk("wr_oe", 64'(dut.u_drv.oe), 64'((k <= WP + 2) ? 1 : 0));
            if (k <= WP + 2) begin
                chk("wr_addr", 64'(addr), 64'h05);
                chk("wr_data", databus, wd);
            end
        end
        wait_idle(idle);
        do_req(1'b0, 6'h05, 3'd0, 64'd0, acc);
        wait_idle(idle);
        chk("rd_occ", 64'(idle - acc), 64'(RW + 1));

        // Vector table: preloads, wrap bursts, overwrites
        foreach (vecs[i]) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].wdata, acc);
            wait_idle(idle);
            chk($sformatf("vec%0d_occ", i), 64'(idle - acc), 64'(vecs[i].occ));
        end

        // req_valid held across a burst, inputs changed mid-op
        @(negedge clk);
        req_write = 1'b0;
        req_addr  = 6'h3E;
        req_len   = 3'd1;
        req_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 20 && acc < 0; i++) begin
            if (req_ready === 1'b1) acc = cyc + 1;
            else @(negedge clk);
        end
        @(posedge clk);
        #1;
        sbq.push_back('{addr: 6'h3E, data: shadow[6'h3E], cyc: acc + RW});
        sbq.push_back('{addr: 6'h3F, data: shadow[6'h3F], cyc: acc + 2 * RW});
        req_addr = 6'h20;
        req_len  = 3'd0;
        acc2 = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                acc2 = cyc + 1;
                chk("b2b_idle", 64'(busy), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        sbq.push_back('{addr: 6'h20, data: shadow[6'h20], cyc: acc2 + RW});
        chk("b2b_gap", 64'(acc2 - acc), 64'(2 * RW + 2));
        wait_idle(idle);

        // Reset during beat 2 of an 8-beat read
        base = nresp;
        do_req(1'b0, 6'h10, 3'd7, 64'd0, acc);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (nresp >= base + 1) break;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_memread", 64'(memread), 64'd0);
        chk("midrst_oe", 64'(dut.u_drv.oe), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_no_resp", 64'(nresp - base), 64'd1);
        do_req(1'b0, 6'h05, 3'd0, 64'd0, acc);
        wait_idle(idle);
        repeat (3) @(negedge clk);

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
